// File: rtl/demux1_4_reg.sv
// demux1_4_reg: 1-to-4 registered demultiplexer.
// One input word per valid/ready handshake is routed to one of four output
// channels, each holding one word behind its own valid/ready handshake.
// Optional feature macro: DEMUX_RR_EN (round-robin target selection, sel ignored).
module demux1_4_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         sel,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [7:0]         word_cnt
);

  localparam int unsigned NCH = 4;

  logic [1:0]       tgt;
  logic             accept;
  logic [NCH-1:0]   load;
  logic [NCH-1:0]   drain;
  logic [WIDTH-1:0] chan_data [NCH];

`ifdef DEMUX_RR_EN
  logic [1:0] rr_ptr;
  logic       unused_sel;

  assign unused_sel = ^sel;
  assign tgt        = rr_ptr;

  // Round-robin pointer advances only on accept, so a full target stalls the stream in order
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= rr_ptr + 2'd1;
    end
  end
`else
  assign tgt = sel;
`endif

  // Handshake decode: target slot free or draining this cycle; per-channel load/drain strobes
  always_comb begin
    in_ready = 1'b0;
    accept   = 1'b0;
    load     = '0;
    drain    = '0;
    if (!reset) begin
      in_ready = !out_valid[tgt] || out_ready[tgt];
    end
    accept = in_valid && in_ready;
    for (int unsigned k = 0; k < NCH; k++) begin
      load[k]  = accept && (tgt == 2'(k));
      drain[k] = out_valid[k] && out_ready[k];
    end
  end

  // Channel holding registers: a load wins over a same-cycle drain to keep full throughput
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        chan_data[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (load[k]) begin
          chan_data[k] <= in_data;
          out_valid[k] <= 1'b1;
        end else if (drain[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Accepted-word counter, wraps modulo 256
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt <= '0;
    end else if (accept) begin
      word_cnt <= word_cnt + 8'd1;
    end
  end

  // Pack channel registers onto the flat output bus
  always_comb begin
    out_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      out_data[k*WIDTH +: WIDTH] = chan_data[k];
    end
  end

endmodule

// File: tb/tb_demux1_4_reg.sv
// tb_demux1_4_reg: directed and randomized checks of demux1_4_reg against a
// behavioural channel model. Honours DEMUX_RR_EN when defined.
module tb_demux1_4_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  word_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the four holding slots
  bit       m_valid [4];
  bit [7:0] m_data  [4];
  int       m_cnt = 0;
  int       m_rr  = 0;
  bit       m_rdy;

  demux1_4_reg #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int target();
`ifdef DEMUX_RR_EN
    return m_rr;
`else
    return int'(sel);
`endif
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_valid[k];
    return v;
  endfunction

  function automatic logic [31:0] exp_data();
    logic [31:0] d;
    for (int k = 0; k < 4; k++) d[k*8 +: 8] = m_data[k];
    return d;
  endfunction

  // One clock cycle: drive, check in_ready, clock, advance model, check outputs
  task automatic step(input bit rst, input bit v, input logic [1:0] s,
                      input logic [7:0] d, input logic [3:0] ordy);
    int t;
    reset = rst; in_valid = v; sel = s; in_data = d; out_ready = ordy;
    #1;
    t = target();
    m_rdy = !rst && (!m_valid[t] || ordy[t]);
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin m_valid[k] = 0; m_data[k] = 8'h00; end
      m_cnt = 0; m_rr = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (v && m_rdy && t == k) begin
          m_valid[k] = 1; m_data[k] = d;
        end else if (m_valid[k] && ordy[k]) begin
          m_valid[k] = 0;
        end
      end
      if (v && m_rdy) begin
        m_cnt = (m_cnt + 1) % 256;
        m_rr  = (m_rr + 1) % 4;
      end
    end
    #1;
    chk("out_valid", {28'd0, out_valid}, {28'd0, exp_valid()});
    chk("out_data", out_data, exp_data());
    chk("word_cnt", {24'd0, word_cnt}, m_cnt);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; sel = 2'd0; in_data = 8'h00; out_ready = 4'h0;
    @(posedge clk); #1;

    // T1: reset held two cycles with in_valid=1
    step(1, 1, 2'd2, 8'hFF, 4'h0);
    step(1, 1, 2'd2, 8'hFF, 4'h0);
    chk("t1_out_valid", {28'd0, out_valid}, 32'h0);
    chk("t1_word_cnt", {24'd0, word_cnt}, 32'h0);
    chk("t1_out_data", out_data, 32'h0);

`ifndef DEMUX_RR_EN
    // T2: route to channel 2
    step(0, 1, 2'd2, 8'hA5, 4'h0);
    chk("t2_out_valid", {28'd0, out_valid}, 32'h4);
    chk("t2_ch2", {24'd0, out_data[23:16]}, 32'hA5);
    chk("t2_word_cnt", {24'd0, word_cnt}, 32'h1);
    // T3: backpressure on full channel 2, then same-cycle drain and accept
    step(0, 1, 2'd2, 8'h3C, 4'h0);
    chk("t3_ch2_hold", {24'd0, out_data[23:16]}, 32'hA5);
    chk("t3_cnt_hold", {24'd0, word_cnt}, 32'h1);
    step(0, 1, 2'd2, 8'h3C, 4'h4);
    chk("t3_ch2_new", {24'd0, out_data[23:16]}, 32'h3C);
    chk("t3_valid2", {31'd0, out_valid[2]}, 32'h1);
    // T4: channel 2 full does not block channel 1
    step(0, 1, 2'd1, 8'h11, 4'h0);
    chk("t4_out_valid", {28'd0, out_valid}, 32'h6);
    chk("t4_ch1", {24'd0, out_data[15:8]}, 32'h11);
`else
    // T6: round-robin ordering with sel held at 3
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 2'd3, 8'(i), 4'hF);
      chk("t6_onehot", {28'd0, out_valid}, 32'(1 << ((i - 1) % 4)));
      chk("t6_word", {24'd0, out_data[((i - 1) % 4)*8 +: 8]}, 32'(i));
    end
    for (int i = 6; i <= 9; i++) step(0, 1, 2'd3, 8'(i), 4'hD);
    chk("t6_ch1_full", {24'd0, out_data[15:8]}, 32'h6);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 2'd3, 8'h0A, 4'hD);
      chk("t6_stall_ready", {31'd0, in_ready}, 32'h0);
      chk("t6_stall_ch1", {24'd0, out_data[15:8]}, 32'h6);
    end
`endif

    // T5: 256 accepts with every consumer ready wraps word_cnt back to 0
    step(1, 0, 2'd0, 8'h00, 4'h0);
    for (int i = 0; i < 256; i++) begin
      step(0, 1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 4'hF);
      if (i == 254) chk("t5_cnt_255", {24'd0, word_cnt}, 32'hFF);
    end
    chk("t5_wrap", {24'd0, word_cnt}, 32'h0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)),
           4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
